// File: rtl/instr_issue_unit_pkg.sv
// Shared constants for the instruction issue unit: FSM state codes, instruction
// field positions and the opcodes the bench and loader care about.
package instr_issue_unit_pkg;

   localparam int unsigned SW     = 3;
   localparam int unsigned InstrW = 16;
   localparam int unsigned OpcHi  = 15;
   localparam int unsigned OpcLo  = 13;
   localparam int unsigned OpHi   = 12;
   localparam int unsigned OpLo   = 11;
   localparam int unsigned OpcW   = OpcHi - OpcLo + 1;
   localparam int unsigned OpW    = OpHi - OpLo + 1;

   localparam logic [OpcW-1:0] OpcMov = 3'b110;
   localparam logic [OpcW-1:0] OpcAlu = 3'b101;

   typedef enum logic [SW-1:0] {
      StIdle  = 3'd0,
      StIssue = 3'd1,
      StAck   = 3'd2,
      StRun   = 3'd3,
      StErr   = 3'd4
   } state_e;

endpackage

// File: rtl/instr_issue_unit_if.sv
// Handshake bundle: loader push port plus the start/wait link to the controller.
interface instr_issue_unit_if;

   logic                                     in_valid;
   logic [instr_issue_unit_pkg::InstrW-1:0]  in_instr;
   logic                                     in_ready;
   logic                                     w;
   logic                                     s;
   logic [instr_issue_unit_pkg::OpcW-1:0]    opcode;
   logic [instr_issue_unit_pkg::OpW-1:0]     op;

   modport master (
      output in_valid, in_instr, w,
      input  in_ready, s, opcode, op
   );

   modport slave (
      input  in_valid, in_instr, w,
      output in_ready, s, opcode, op
   );

endinterface

// File: rtl/instr_issue_unit_fifo.sv
// Small instruction FIFO; pushes at full are dropped, push and pop may coincide.
module instr_issue_unit_fifo #(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [Width-1:0] wdata,
   output logic [Width-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]    count_q;
   logic             do_push, do_pop;

   assign full    = (count_q == (PtrW+1)'(Depth));
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem_q[rd_ptr_q];

   // Pointers wrap naturally because Depth is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         if (do_push && !do_pop)      count_q <= count_q + (PtrW+1)'(1);
         else if (!do_push && do_pop) count_q <= count_q - (PtrW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/instr_issue_unit.sv
// Issues buffered instructions to the control FSM over the s/w handshake,
// watching for acceptance and completion with timeouts, and counts completions.
module instr_issue_unit
   import instr_issue_unit_pkg::*;
#(
   parameter int unsigned Depth      = 4,
   parameter int unsigned AckTimeout = 4,
   parameter int unsigned RunTimeout = 16,
   parameter int unsigned CntW       = 8
) (
   input  logic                clk,
   input  logic                reset,
   instr_issue_unit_if.slave   iss,
   input  logic                err_clr,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [CntW-1:0]     issued_cnt
);

   localparam int unsigned TMax   = (RunTimeout > AckTimeout) ? RunTimeout : AckTimeout;
   localparam int unsigned TimerW = (TMax > 2) ? $clog2(TMax) : 1;

   state_e            state_q, state_d;
   logic [TimerW-1:0] timer_q, timer_d;
   logic              s_q, s_d;
   logic [OpcW-1:0]   opcode_q, opcode_d;
   logic [OpW-1:0]    op_q, op_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [CntW-1:0]   cnt_q, cnt_d;

   logic              pop, full, empty;
   logic [InstrW-1:0] head;
   logic              unused_head_lo;

   instr_issue_unit_fifo #(
      .Depth (Depth),
      .Width (InstrW)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (iss.in_valid),
      .pop   (pop),
      .wdata (iss.in_instr),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );

   assign unused_head_lo = ^head[OpLo-1:0];

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      s_d      = 1'b0;
      opcode_d = opcode_q;
      op_d     = op_q;
      done_d   = 1'b0;
      err_d    = err_q;
      cnt_d    = cnt_q;
      pop      = 1'b0;
      unique case (state_q)
         StIdle: begin
            // Only start when the controller reports idle, so done and the next s never touch.
            if (!empty && iss.w) begin
               pop      = 1'b1;
               opcode_d = head[OpcHi:OpcLo];
               op_d     = head[OpHi:OpLo];
               s_d      = 1'b1;
               state_d  = StIssue;
            end
         end
         StIssue: begin
            timer_d = '0;
            state_d = StAck;
         end
         StAck: begin
            if (!iss.w) begin
               timer_d = '0;
               state_d = StRun;
            end else if (timer_q == TimerW'(AckTimeout - 1)) begin
               err_d   = 1'b1;
               state_d = StErr;
            end else begin
               timer_d = timer_q + TimerW'(1);
            end
         end
         StRun: begin
            if (iss.w) begin
               done_d  = 1'b1;
               cnt_d   = cnt_q + CntW'(1);
               state_d = StIdle;
            end else if (timer_q == TimerW'(RunTimeout - 1)) begin
               err_d   = 1'b1;
               state_d = StErr;
            end else begin
               timer_d = timer_q + TimerW'(1);
            end
         end
         StErr: begin
            if (err_clr) begin
               err_d   = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         timer_q  <= '0;
         s_q      <= 1'b0;
         opcode_q <= '0;
         op_q     <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         s_q      <= s_d;
         opcode_q <= opcode_d;
         op_q     <= op_d;
         done_q   <= done_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   end

   assign iss.in_ready = ~full;
   assign iss.s        = s_q;
   assign iss.opcode   = opcode_q;
   assign iss.op       = op_q;
   assign busy         = (state_q == StIssue) || (state_q == StAck) || (state_q == StRun);
   assign done         = done_q;
   assign err          = err_q;
   assign issued_cnt   = cnt_q;

endmodule

// File: tb/tb_instr_issue_unit.sv
// Scoreboard bench for instr_issue_unit driven by a behavioural control stub.
module tb_instr_issue_unit;
   import instr_issue_unit_pkg::*;

   localparam int unsigned CntW = 8;

   logic            clk;
   logic            reset;
   logic            err_clr;
   logic            busy, done, err;
   logic [CntW-1:0] issued_cnt;

   instr_issue_unit_if ifc ();

   instr_issue_unit #(
      .Depth      (4),
      .AckTimeout (4),
      .RunTimeout (16),
      .CntW       (CntW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .iss        (ifc),
      .err_clr    (err_clr),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .issued_cnt (issued_cnt)
   );

   int errors = 0;
   int checks = 0;
   int exp_cnt = 0;
   logic [4:0] sb [$];
   int         dq [$];

   // Control stub: drops w after seeing s, raises it stub_n cycles later.
   logic stub_w, stub_act, stub_drop, stub_raise, w_force0;
   int   stub_n, stub_cnt;
   assign ifc.w = stub_w & ~w_force0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      stub_w = 1'b1; stub_act = 1'b0; stub_cnt = 0;
      forever begin
         @(negedge clk or negedge reset);
         if (!reset) begin
            stub_w = 1'b1; stub_act = 1'b0; stub_cnt = 0;
         end else if (!clk) begin
            if (stub_act) begin
               if (stub_raise) begin
                  if (stub_cnt <= 1) begin
                     stub_w = 1'b1; stub_act = 1'b0;
                  end else stub_cnt--;
               end
            end else if (ifc.s && stub_drop) begin
               stub_w = 1'b0; stub_cnt = stub_n; stub_act = 1'b1;
            end
         end
      end
   end

   // Monitor: every s pulse and done pulse is matched against the scoreboard.
   initial begin
      logic [4:0] e5;
      int ec;
      forever begin
         @(negedge clk);
         if (reset) begin
            if (ifc.s) begin
               if (sb.size() == 0) check("unexpected_s", {27'd0, ifc.opcode, ifc.op}, 32'hFFFF);
               else begin
                  e5 = sb.pop_front();
                  check("issue_opcode_op", {27'd0, ifc.opcode, ifc.op}, {27'd0, e5});
               end
            end
            if (done) begin
               if (dq.size() == 0) check("unexpected_done", {24'd0, issued_cnt}, 32'hFFFF);
               else begin
                  ec = dq.pop_front();
                  check("done_issued_cnt", {24'd0, issued_cnt}, ec);
               end
            end
         end
      end
   end

   task automatic push(input logic [15:0] instr, input logic [2:0] opc, input logic [1:0] opv,
                       input bit exp_issue, input bit exp_done);
      if (exp_issue) sb.push_back({opc, opv});
      if (exp_done) begin
         exp_cnt++;
         dq.push_back(exp_cnt);
      end
      ifc.in_valid = 1'b1;
      ifc.in_instr = instr;
      @(posedge clk); #1;
      ifc.in_valid = 1'b0;
   endtask

   task automatic drain(input string name, input int maxc);
      bit ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && dq.size() == 0 && !busy && !done) begin
            ok = 1'b1;
            break;
         end
      end
      check({name, "_drained"}, {31'd0, ok}, 32'd1);
      @(posedge clk); #1;
   endtask

   // Returns cycles from the s pulse until err rises (0 on timeout).
   task automatic s_to_err(output int n);
      bit seen = 1'b0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ifc.s) begin seen = 1'b1; break; end
      end
      if (seen) begin
         for (int i = 1; i < 40; i++) begin
            @(negedge clk);
            if (err) begin n = i; break; end
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      int n;
      bit hit;
      reset = 1'b0; err_clr = 1'b0; ifc.in_valid = 1'b0; ifc.in_instr = '0;
      stub_drop = 1'b1; stub_raise = 1'b1; stub_n = 5; w_force0 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_s", {31'd0, ifc.s}, 0);
      check("rst_opcode", {29'd0, ifc.opcode}, 0);
      check("rst_op", {30'd0, ifc.op}, 0);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_done", {31'd0, done}, 0);
      check("rst_err", {31'd0, err}, 0);
      check("rst_cnt", {24'd0, issued_cnt}, 0);
      check("rst_in_ready", {31'd0, ifc.in_ready}, 1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;

      // 1: single instruction
      push(16'hA000, OpcAlu, 2'b00, 1, 1);
      drain("t1", 40);
      check("t1_cnt", {24'd0, issued_cnt}, 1);
      check("t1_busy", {31'd0, busy}, 0);

      // 2: back-to-back MVN, MOV, CMP
      stub_n = 3;
      push(16'hB800, OpcAlu, 2'b11, 1, 1);
      push(16'hD000, OpcMov, 2'b10, 1, 1);
      push(16'hA800, OpcAlu, 2'b01, 1, 1);
      drain("t2", 80);
      check("t2_cnt", {24'd0, issued_cnt}, 4);

      // 3: fill FIFO while controller busy; fifth push dropped
      w_force0 = 1'b1;
      stub_n = 2;
      push(16'hA000, OpcAlu, 2'b00, 1, 1);
      push(16'hB000, OpcAlu, 2'b10, 1, 1);
      push(16'hC800, 3'b110, 2'b01, 1, 1);
      check("t3_ready_3", {31'd0, ifc.in_ready}, 1);
      push(16'h2000, 3'b001, 2'b00, 1, 1);
      check("t3_ready_full", {31'd0, ifc.in_ready}, 0);
      push(16'hE000, 3'b111, 2'b00, 0, 0);
      repeat (3) @(posedge clk); #1;
      check("t3_no_issue_w0", {27'd0, 5'(sb.size())}, 4);
      w_force0 = 1'b0;
      drain("t3", 80);
      check("t3_cnt", {24'd0, issued_cnt}, 8);
      check("t3_ready_after", {31'd0, ifc.in_ready}, 1);

      // 4: ack timeout, then recovery through err_clr
      stub_drop = 1'b0;
      push(16'hA000, OpcAlu, 2'b00, 1, 0);
      s_to_err(n);
      check("t4_ack_timeout_cycles", n, 5);
      check("t4_err", {31'd0, err}, 1);
      check("t4_busy", {31'd0, busy}, 0);
      push(16'hD000, OpcMov, 2'b10, 1, 1);
      repeat (6) @(posedge clk); #1;
      check("t4_no_issue_in_err", {27'd0, 5'(sb.size())}, 1);
      stub_drop = 1'b1;
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      check("t4_err_cleared", {31'd0, err}, 0);
      drain("t4", 40);
      check("t4_cnt", {24'd0, issued_cnt}, 9);

      // 5: run timeout, controller never finishes
      stub_raise = 1'b0;
      push(16'hA800, OpcAlu, 2'b01, 1, 0);
      s_to_err(n);
      check("t5_run_timeout_cycles", n, 18);
      check("t5_cnt", {24'd0, issued_cnt}, 9);
      stub_raise = 1'b1;
      repeat (8) @(posedge clk); #1;
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      check("t5_err_cleared", {31'd0, err}, 0);
      check("t5_busy", {31'd0, busy}, 0);

      // 6: reset during run with two instructions queued
      stub_n = 10;
      push(16'hD000, OpcMov, 2'b10, 1, 0);
      push(16'hA000, OpcAlu, 2'b00, 0, 0);
      push(16'hB800, OpcAlu, 2'b11, 0, 0);
      hit = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy && !ifc.w) begin hit = 1'b1; break; end
      end
      check("t6_reached_run", {31'd0, hit}, 1);
      repeat (2) @(posedge clk); #1;
      reset = 1'b0;
      sb.delete();
      dq.delete();
      exp_cnt = 0;
      @(negedge clk);
      check("t6_rst_s", {31'd0, ifc.s}, 0);
      check("t6_rst_busy", {31'd0, busy}, 0);
      check("t6_rst_cnt", {24'd0, issued_cnt}, 0);
      check("t6_rst_in_ready", {31'd0, ifc.in_ready}, 1);
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (10) @(posedge clk); #1;
      check("t6_idle_after", {31'd0, busy}, 0);
      stub_n = 3;
      push(16'hA000, OpcAlu, 2'b00, 1, 1);
      drain("t6", 40);
      check("t6_cnt", {24'd0, issued_cnt}, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
